// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router input sequencer.
package router_pkg;

  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned DATA_W    = 8;

  // Address 2'b11 has no FIFO behind it; such packets are swallowed.
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    StDecode,
    StWaitEmpty,
    StLoadFirst,
    StLoadData,
    StCheckParity,
    StDrop
  } state_e;

endpackage

// File: rtl/router_sto_timer.sv
// Per-port stall timeout: pulses soft_reset_o when a valid port goes unread for TIMEOUT cycles.
module router_sto_timer #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld_i,
  input  logic read_enb_i,
  output logic soft_reset_o
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d        = '0;
    soft_reset_o = 1'b0;
    if (vld_i && !read_enb_i) begin
      if (cnt_q == CntLast) begin
        soft_reset_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/router_ctrl_fsm.sv
// Router input sequencer: parses header/payload/parity packets and steers bytes into 3 FIFOs.
// Optional parity compare enabled by defining ROUTER_PARITY_CHECK_EN.
module router_ctrl_fsm
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pkt_valid_i,
  input  logic [DATA_W-1:0]    data_in_i,
  input  logic [NUM_PORTS-1:0] fifo_full_i,
  input  logic [NUM_PORTS-1:0] fifo_empty_i,
  input  logic [NUM_PORTS-1:0] read_enb_i,
  output logic                 busy_o,
  output logic [NUM_PORTS-1:0] write_enb_o,
  output logic                 lfd_state_o,
  output logic [DATA_W-1:0]    fifo_din_o,
  output logic [NUM_PORTS-1:0] vld_out_o,
  output logic [NUM_PORTS-1:0] soft_reset_o,
  output logic                 parity_err_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [1:0]        sel_q, sel_d;
  logic              sel_full, sel_sr;
  logic [NUM_PORTS-1:0] sel_onehot;
`ifdef ROUTER_PARITY_CHECK_EN
  logic [DATA_W-1:0] par_acc_q, par_acc_d;
  logic [DATA_W-1:0] par_rx_q, par_rx_d;
`endif

  assign vld_out_o  = ~fifo_empty_i;
  assign sel_full   = fifo_full_i[sel_q];
  assign sel_sr     = soft_reset_o[sel_q];
  assign sel_onehot = NUM_PORTS'(1) << sel_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_sto
    router_sto_timer #(
      .TIMEOUT(TIMEOUT)
    ) u_timer (
      .clock       (clock),
      .resetn      (resetn),
      .vld_i       (vld_out_o[i]),
      .read_enb_i  (read_enb_i[i]),
      .soft_reset_o(soft_reset_o[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    sel_d       = sel_q;
    busy_o      = 1'b0;
    write_enb_o = '0;
    lfd_state_o = 1'b0;
    fifo_din_o  = data_in_i;
`ifdef ROUTER_PARITY_CHECK_EN
    par_acc_d    = par_acc_q;
    par_rx_d     = par_rx_q;
    parity_err_o = 1'b0;
`endif
    unique case (state_q)
      StDecode: begin
        if (pkt_valid_i) begin
          if (data_in_i[1:0] != ADDR_INVALID) begin
            hdr_d   = data_in_i;
            sel_d   = data_in_i[1:0];
`ifdef ROUTER_PARITY_CHECK_EN
            par_acc_d = data_in_i;
`endif
            state_d = fifo_empty_i[data_in_i[1:0]] ? StLoadFirst : StWaitEmpty;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StWaitEmpty: begin
        busy_o = 1'b1;
        if (sel_sr) begin
          state_d = StDrop;
        end else if (fifo_empty_i[sel_q]) begin
          state_d = StLoadFirst;
        end
      end
      StLoadFirst: begin
        busy_o      = 1'b1;
        write_enb_o = sel_onehot;
        lfd_state_o = 1'b1;
        fifo_din_o  = hdr_q;
        state_d     = sel_sr ? StDrop : StLoadData;
      end
      StLoadData: begin
        busy_o = sel_full;
        if (!sel_full) begin
          write_enb_o = sel_onehot;
          if (pkt_valid_i) begin
`ifdef ROUTER_PARITY_CHECK_EN
            par_acc_d = par_acc_q ^ data_in_i;
`endif
            if (sel_sr) state_d = StDrop;
          end else begin
            // Accepting the parity beat wins over a same-cycle timeout.
`ifdef ROUTER_PARITY_CHECK_EN
            par_rx_d = data_in_i;
`endif
            state_d = StCheckParity;
          end
        end else if (sel_sr) begin
          state_d = StDrop;
        end
      end
      StCheckParity: begin
        busy_o  = 1'b1;
`ifdef ROUTER_PARITY_CHECK_EN
        parity_err_o = (par_acc_q != par_rx_q);
`endif
        state_d = StDecode;
      end
      StDrop: begin
        if (!pkt_valid_i) state_d = StDecode;
      end
      default: state_d = StDecode;
    endcase
  end

`ifndef ROUTER_PARITY_CHECK_EN
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= StDecode;
      hdr_q   <= '0;
      sel_q   <= '0;
`ifdef ROUTER_PARITY_CHECK_EN
      par_acc_q <= '0;
      par_rx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      sel_q   <= sel_d;
`ifdef ROUTER_PARITY_CHECK_EN
      par_acc_q <= par_acc_d;
      par_rx_q  <= par_rx_d;
`endif
    end
  end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Self-checking bench for router_ctrl_fsm: directed scenarios plus random packets vs a
// packet-level reference (expected FIFO write stream, parity outcome, timeout arithmetic).
module tb_router_ctrl_fsm;

  localparam int TIMEOUT = 30;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] fifo_full = 3'b000;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] read_enb = 3'b000;
  logic       busy;
  logic [2:0] write_enb;
  logic       lfd_state;
  logic [7:0] fifo_din;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;
  logic       parity_err;

  router_ctrl_fsm #(
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .pkt_valid_i (pkt_valid),
    .data_in_i   (data_in),
    .fifo_full_i (fifo_full),
    .fifo_empty_i(fifo_empty),
    .read_enb_i  (read_enb),
    .busy_o      (busy),
    .write_enb_o (write_enb),
    .lfd_state_o (lfd_state),
    .fifo_din_o  (fifo_din),
    .vld_out_o   (vld_out),
    .soft_reset_o(soft_reset),
    .parity_err_o(parity_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       lfd;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_errors = 0;
  int  par_pulses = 0;
  int  exp_par_pulses = 0;
  bit  rand_full_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every FIFO write must match the next byte the packet model predicts.
  always @(negedge clock) begin
    if (resetn) begin
      if (parity_err) par_pulses++;
      if (write_enb != 3'b000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(write_enb), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_port", 32'(write_enb), 32'd1 << mon_e.port);
          check("wr_data", 32'(fifo_din), 32'(mon_e.data));
          check("wr_lfd", 32'(lfd_state), 32'(mon_e.lfd));
        end
        if (!lfd_state) check("wr_while_full", 32'(write_enb & fifo_full), 32'd0);
      end
    end
  end

  task automatic push_exp(input int port, input logic [7:0] d, input logic lfd);
    wr_t e;
    e.port = port;
    e.data = d;
    e.lfd  = lfd;
    exp_q.push_back(e);
  endtask

  // Present one beat and hold it until accepted (busy low at the clock edge).
  task automatic beat(input logic v, input logic [7:0] d);
    int n;
    n = 0;
    pkt_valid = v;
    data_in   = d;
    forever begin
      if (rand_full_en) for (int i = 0; i < 3; i++) fifo_full[i] = ($urandom_range(0, 3) == 0);
      @(negedge clock);
      if (!busy) break;
      n++;
      if (n > 200) begin
        n_checks++;
        n_errors++;
        $error("FAIL beat_wait observed=busy_stuck expected=accept_within_200");
        @(posedge clock);
        #1;
        return;
      end
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1;
  endtask

  // Checks made in the cycle right after the parity beat of a routed packet.
  task automatic pkt_tail(input bit bad);
    check("tail_busy", 32'(busy), 32'd1);
`ifdef ROUTER_PARITY_CHECK_EN
    check("parity_err", 32'(parity_err), 32'(bad));
    if (bad) exp_par_pulses++;
`else
    check("parity_err", 32'(parity_err), 32'(1'b0 & bad));
`endif
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_pkt(input logic [1:0] addr, input int n, input bit bad);
    logic [7:0] hdr, par, p;
    logic [7:0] pay[$];
    hdr = {6'(n), addr};
    par = hdr;
    for (int i = 0; i < n; i++) begin
      p = 8'($urandom);
      pay.push_back(p);
      par ^= p;
    end
    if (bad) par ^= 8'($urandom_range(1, 255));
    if (addr != 2'b11) begin
      push_exp(int'(addr), hdr, 1'b1);
      foreach (pay[i]) push_exp(int'(addr), pay[i], 1'b0);
      push_exp(int'(addr), par, 1'b0);
    end
    beat(1'b1, hdr);
    foreach (pay[i]) begin
      beat(1'b1, pay[i]);
      if (addr == 2'b11) check("drop_busy", 32'(busy), 32'd0);
    end
    beat(1'b0, par);
    if (addr != 2'b11) pkt_tail(bad);
    else check("drop_done_busy", 32'(busy), 32'd0);
    pkt_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, pulses, others;
    logic [7:0] hdr, par;

    // Reset values
    fifo_empty = 3'b101;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_write_enb", 32'(write_enb), 32'd0);
    check("rst_lfd", 32'(lfd_state), 32'd0);
    check("rst_soft_reset", 32'(soft_reset), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_vld_out", 32'(vld_out), 32'h2);
    fifo_empty = 3'b111;
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // 1: header 8'h0D, three payloads, good parity
    send_pkt(2'b01, 3, 1'b0);

    // 2: target FIFO not empty for 4 cycles after the header
    fifo_empty[0] = 1'b0;
    hdr = {6'd2, 2'b00};
    par = hdr ^ 8'hA1 ^ 8'hB2;
    push_exp(0, hdr, 1'b1);
    push_exp(0, 8'hA1, 1'b0);
    push_exp(0, 8'hB2, 1'b0);
    push_exp(0, par, 1'b0);
    beat(1'b1, hdr);
    for (int k = 0; k < 4; k++) begin
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_nowrite", 32'(write_enb), 32'd0);
      @(posedge clock);
      #1;
    end
    check("wait_q_pending", 32'(exp_q.size()), 32'd4);
    fifo_empty[0] = 1'b1;
    beat(1'b1, 8'hA1);
    beat(1'b1, 8'hB2);
    beat(1'b0, par);
    pkt_tail(1'b0);
    pkt_valid = 1'b0;

    // 3: FIFO2 fills for 3 cycles mid-payload
    hdr = {6'd4, 2'b10};
    par = hdr ^ 8'hC1 ^ 8'hC2 ^ 8'hC3 ^ 8'hC4;
    push_exp(2, hdr, 1'b1);
    push_exp(2, 8'hC1, 1'b0);
    push_exp(2, 8'hC2, 1'b0);
    push_exp(2, 8'hC3, 1'b0);
    push_exp(2, 8'hC4, 1'b0);
    push_exp(2, par, 1'b0);
    beat(1'b1, hdr);
    beat(1'b1, 8'hC1);
    data_in      = 8'hC2;
    fifo_full[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("full_busy", 32'(busy), 32'd1);
      check("full_nowrite", 32'(write_enb), 32'd0);
      @(posedge clock);
      #1;
    end
    fifo_full[2] = 1'b0;
    beat(1'b1, 8'hC2);
    beat(1'b1, 8'hC3);
    beat(1'b1, 8'hC4);
    beat(1'b0, par);
    pkt_tail(1'b0);
    pkt_valid = 1'b0;

    // 4: invalid address, 4 payloads + parity all discarded
    send_pkt(2'b11, 4, 1'b0);

    // 5: port 0 valid and never read; then port 1 read once at cycle 20
    fifo_empty[0] = 1'b0;
    first  = -1;
    pulses = 0;
    others = 0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clock);
      if (soft_reset[0]) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (soft_reset[2:1] != 2'b00) others++;
      @(posedge clock);
      #1;
    end
    check("sto0_cycle", 32'(first), 32'(TIMEOUT));
    check("sto0_pulses", 32'(pulses), 32'd1);
    check("sto_other_ports", 32'(others), 32'd0);
    fifo_empty[0] = 1'b1;
    fifo_empty[1] = 1'b0;
    first  = -1;
    pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      read_enb[1] = (k == 20);
      @(negedge clock);
      if (soft_reset[1]) begin
        pulses++;
        if (first < 0) first = k;
      end
      @(posedge clock);
      #1;
    end
    read_enb[1] = 1'b0;
    check("sto1_cycle_after_read", 32'(first), 32'(20 + TIMEOUT));
    check("sto1_pulses", 32'(pulses), 32'd1);
    fifo_empty[1] = 1'b1;
    @(posedge clock);
    #1;

    // Timeout while waiting for an empty FIFO drops the whole packet
    fifo_empty[0] = 1'b0;
    hdr = {6'd2, 2'b00};
    beat(1'b1, hdr);
    beat(1'b1, 8'h11);
    check("sto_drop_busy", 32'(busy), 32'd0);
    beat(1'b1, 8'h22);
    beat(1'b0, hdr ^ 8'h33);
    pkt_valid = 1'b0;
    fifo_empty[0] = 1'b1;
    check("sto_drop_nowrite", 32'(exp_q.size()), 32'd0);
    send_pkt(2'b00, 2, 1'b0);

    // 6: corrupted parity byte
    send_pkt(2'b01, 2, 1'b1);

    // Reset in the middle of a packet
    hdr = {6'd3, 2'b01};
    push_exp(1, hdr, 1'b1);
    push_exp(1, 8'h5A, 1'b0);
    beat(1'b1, hdr);
    beat(1'b1, 8'h5A);
    resetn    = 1'b0;
    pkt_valid = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_write", 32'(write_enb), 32'd0);
    check("midrst_lfd", 32'(lfd_state), 32'd0);
    check("midrst_q", 32'(exp_q.size()), 32'd0);
    send_pkt(2'b10, 1, 1'b0);

    // Random packets with random FIFO-full stalls
    rand_full_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      send_pkt(2'($urandom_range(0, 3)), int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0));
    end
    rand_full_en = 1'b0;
    fifo_full    = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    check("parity_pulse_total", 32'(par_pulses), 32'(exp_par_pulses));
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
